// File: rtl/silent_pkg.sv
// Shared types and defaults for the per-transducer slew limiter.
package silent_pkg;

  localparam int SLPF_WIDTH = 13;
  localparam int SLPF_DEPTH = 249;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } sweep_state_t;

  // One channel's worth of inputs as seen by the step computation.
  typedef struct packed {
    logic [SLPF_WIDTH-1:0] cycle;
    logic [SLPF_WIDTH-1:0] tgt_duty;
    logic [SLPF_WIDTH-1:0] tgt_phase;
    logic [SLPF_WIDTH-1:0] cur_duty;
    logic [SLPF_WIDTH-1:0] cur_phase;
  } lane_t;

  // Two guard bits: one for the sign of a difference, one for the circular
  // adjustment and the step-add before wrapping.
  typedef logic signed [SLPF_WIDTH+1:0] swide_t;

  function automatic swide_t widen(input logic [SLPF_WIDTH-1:0] v);
    return swide_t'({2'b00, v});
  endfunction

endpackage

// File: rtl/silent_lpf_unit.sv
// Combinational one-channel step: sanitise targets, take the circular phase
// delta along the shorter arc, clamp both moves to the step, wrap phase.
module silent_lpf_unit
  import silent_pkg::*;
(
  input  lane_t                 lane,
  input  logic [SLPF_WIDTH-1:0] step_duty,
  input  logic [SLPF_WIDTH-1:0] step_phase,
  input  logic                  enable,
  output logic [SLPF_WIDTH-1:0] nxt_duty,
  output logic [SLPF_WIDTH-1:0] nxt_phase
);

  logic [SLPF_WIDTH-1:0] san_duty;
  logic [SLPF_WIDTH-1:0] san_phase;
  swide_t                cyc_w;
  swide_t                half_w;
  swide_t                dd;
  swide_t                dd_mag;
  swide_t                dp;
  swide_t                dp_mag;
  swide_t                ph_w;

  // Step computation; bypass (enable=0) lands directly on the sanitised targets.
  always_comb begin
    san_duty  = lane.tgt_duty;
    san_phase = lane.tgt_phase;
    if (lane.tgt_duty > lane.cycle) san_duty = lane.cycle;
    if (lane.tgt_phase >= lane.cycle) san_phase = lane.tgt_phase - lane.cycle;

    cyc_w  = widen(lane.cycle);
    half_w = cyc_w >>> 1;

    dd     = widen(san_duty) - widen(lane.cur_duty);
    dd_mag = dd[SLPF_WIDTH+1] ? -dd : dd;
    nxt_duty = san_duty;
    if (enable && (dd_mag > widen(step_duty))) begin
      nxt_duty = dd[SLPF_WIDTH+1] ? (lane.cur_duty - step_duty)
                                  : (lane.cur_duty + step_duty);
    end

    // A half-period tie on an even cycle is resolved in the positive direction.
    dp = widen(san_phase) - widen(lane.cur_phase);
    if (dp > half_w) begin
      dp = dp - cyc_w;
    end else if ((dp < -half_w) || ((dp == -half_w) && !lane.cycle[0])) begin
      dp = dp + cyc_w;
    end
    dp_mag = dp[SLPF_WIDTH+1] ? -dp : dp;

    ph_w = widen(san_phase);
    if (enable && (dp_mag > widen(step_phase))) begin
      ph_w = dp[SLPF_WIDTH+1] ? (widen(lane.cur_phase) - widen(step_phase))
                              : (widen(lane.cur_phase) + widen(step_phase));
      if (ph_w >= cyc_w) begin
        ph_w = ph_w - cyc_w;
      end else if (ph_w[SLPF_WIDTH+1]) begin
        ph_w = ph_w + cyc_w;
      end
    end
    nxt_phase = ph_w[SLPF_WIDTH-1:0];
  end

endmodule

// File: rtl/silent_lpf_v3.sv
// Per-transducer slew limiter: one serial sweep over all channels per START
// rising edge, two-stage pipeline (compute, then write back).
//
//   state | meaning
//   IDLE  | waiting for an accepted START edge
//   SWEEP | presenting channel idx to the step unit, one channel per clock
//   DRAIN | last channel sits in the pipeline register, write pending
//
// BUSY also covers the final write-back and the DONE cycle, so a START edge
// arriving in that tail is reported as OVERRUN rather than starting a sweep.
module silent_lpf_v3
  import silent_pkg::*;
#(
  parameter int DEPTH = SLPF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic [SLPF_WIDTH-1:0] step_duty,
  input  logic [SLPF_WIDTH-1:0] step_phase,
  input  logic [SLPF_WIDTH-1:0] cycle   [DEPTH],
  input  logic [SLPF_WIDTH-1:0] duty    [DEPTH],
  input  logic [SLPF_WIDTH-1:0] phase   [DEPTH],
  output logic [SLPF_WIDTH-1:0] duty_s  [DEPTH],
  output logic [SLPF_WIDTH-1:0] phase_s [DEPTH],
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int W     = SLPF_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  sweep_state_t      state;
  sweep_state_t      state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              start_q;
  logic              start_rise;
  logic              accept;
  logic              en_lat;
  logic [W-1:0]      step_duty_lat;
  logic [W-1:0]      step_phase_lat;

  lane_t             lane;
  logic [W-1:0]      nxt_duty;
  logic [W-1:0]      nxt_phase;

  logic              p1_valid;
  logic              p1_last;
  logic [IDX_W-1:0]  p1_idx;
  logic [W-1:0]      p1_duty;
  logic [W-1:0]      p1_phase;
  logic              wr_last;
  logic              done_q;
  logic              overrun_q;

  assign start_rise = start & ~start_q;
  assign busy       = (state != IDLE) | p1_valid | wr_last | done_q;
  assign accept     = start_rise & ~busy;
  assign done       = done_q;
  assign overrun    = overrun_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SWEEP;
      SWEEP:   if (idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edge detect, sweep index and per-sweep latched controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q        <= 1'b0;
      idx            <= '0;
      en_lat         <= 1'b0;
      step_duty_lat  <= '0;
      step_phase_lat <= '0;
    end else begin
      start_q <= start;
      if (accept) begin
        idx            <= '0;
        en_lat         <= enable;
        step_duty_lat  <= step_duty;
        step_phase_lat <= step_phase;
      end else if ((state == SWEEP) && (idx != LAST_IDX)) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Stage 1 read mux for the channel under the index.
  always_comb begin
    lane.cycle     = cycle[idx];
    lane.tgt_duty  = duty[idx];
    lane.tgt_phase = phase[idx];
    lane.cur_duty  = duty_s[idx];
    lane.cur_phase = phase_s[idx];
  end

  silent_lpf_unit u_unit (
    .lane       (lane),
    .step_duty  (step_duty_lat),
    .step_phase (step_phase_lat),
    .enable     (en_lat),
    .nxt_duty   (nxt_duty),
    .nxt_phase  (nxt_phase)
  );

  // Pipeline register between compute and write-back, plus status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid  <= 1'b0;
      p1_last   <= 1'b0;
      p1_idx    <= '0;
      p1_duty   <= '0;
      p1_phase  <= '0;
      wr_last   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      p1_valid  <= (state == SWEEP);
      p1_last   <= (state == SWEEP) && (idx == LAST_IDX);
      p1_idx    <= idx;
      p1_duty   <= nxt_duty;
      p1_phase  <= nxt_phase;
      wr_last   <= p1_valid & p1_last;
      done_q    <= wr_last;
      overrun_q <= start_rise & busy;
    end
  end

  // Write-back; only the channel in stage 2 changes, all others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        duty_s[i]  <= '0;
        phase_s[i] <= '0;
      end
    end else if (p1_valid) begin
      duty_s[p1_idx]  <= p1_duty;
      phase_s[p1_idx] <= p1_phase;
    end
  end

endmodule

// File: tb/tb_silent_lpf_v3.sv
// Directed bench for the slew limiter: one task per scenario.
module tb_silent_lpf_v3;

  localparam int W = 13;
  localparam int D = 249;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] step_duty = '0;
  logic [W-1:0] step_phase = '0;
  logic [W-1:0] cyc     [D];
  logic [W-1:0] duty    [D];
  logic [W-1:0] phase   [D];
  logic [W-1:0] duty_s  [D];
  logic [W-1:0] phase_s [D];
  logic         busy, done, overrun;

  logic [W-1:0] exp_d [D];
  logic [W-1:0] exp_p [D];

  int n_checks = 0;
  int n_fail   = 0;

  silent_lpf_v3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .start      (start),
    .step_duty  (step_duty),
    .step_phase (step_phase),
    .cycle      (cyc),
    .duty       (duty),
    .phase      (phase),
    .duty_s     (duty_s),
    .phase_s    (phase_s),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Raise START, return the number of edges from the START edge to DONE.
  task automatic run_sweep(output int lat);
    lat = -1;
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL sweep_timeout: done never seen, required within 400 cycles");
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < D; i++) begin
      cyc[i] = 13'd5000; duty[i] = '0; phase[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {busy, done, overrun});
    end
    n_checks++;
    if (duty_s[0] !== 13'd0 || phase_s[248] !== 13'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %0d/%0d required 0/0", duty_s[0], phase_s[248]);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_duty_ramp();
    int lat;
    enable = 1'b1; step_duty = 13'd100; step_phase = 13'd100;
    duty[0] = 13'd2500;
    run_sweep(lat);
    n_checks++;
    if (lat !== 251) begin
      n_fail++; $display("FAIL ramp_latency: got %0d required 251", lat);
    end
    repeat (23) run_sweep(lat);
    n_checks++;
    if (duty_s[0] !== 13'd2400) begin
      n_fail++; $display("FAIL ramp_24: got %0d required 2400", duty_s[0]);
    end
    run_sweep(lat);
    n_checks++;
    if (duty_s[0] !== 13'd2500) begin
      n_fail++; $display("FAIL ramp_25: got %0d required 2500", duty_s[0]);
    end
    run_sweep(lat);
    n_checks++;
    if (duty_s[0] !== 13'd2500 || duty_s[1] !== 13'd0) begin
      n_fail++; $display("FAIL ramp_hold: got %0d/%0d required 2500/0", duty_s[0], duty_s[1]);
    end
  endtask

  task automatic test_clamp();
    int lat;
    duty[0] = 13'd2450; step_duty = 13'd5000;
    run_sweep(lat);
    n_checks++;
    if (duty_s[0] !== 13'd2450) begin
      n_fail++; $display("FAIL big_step: got %0d required 2450", duty_s[0]);
    end
    duty[0] = 13'd2500; step_duty = 13'd100;
    run_sweep(lat);
    n_checks++;
    if (duty_s[0] !== 13'd2500) begin
      n_fail++; $display("FAIL clamp: got %0d required 2500", duty_s[0]);
    end
    duty[0] = 13'd0; step_duty = 13'd0;
    run_sweep(lat);
    n_checks++;
    if (duty_s[0] !== 13'd2500) begin
      n_fail++; $display("FAIL step_zero: got %0d required 2500", duty_s[0]);
    end
  endtask

  task automatic test_phase_wrap();
    int lat;
    step_duty = 13'd100;
    duty[0] = 13'd2500;
    phase[0] = 13'd100; step_phase = 13'd5000;
    run_sweep(lat);
    n_checks++;
    if (phase_s[0] !== 13'd100) begin
      n_fail++; $display("FAIL phase_set: got %0d required 100", phase_s[0]);
    end
    phase[0] = 13'd4950; step_phase = 13'd100;
    run_sweep(lat);
    n_checks++;
    if (phase_s[0] !== 13'd0) begin
      n_fail++; $display("FAIL phase_wrap1: got %0d required 0", phase_s[0]);
    end
    run_sweep(lat);
    n_checks++;
    if (phase_s[0] !== 13'd4950) begin
      n_fail++; $display("FAIL phase_wrap2: got %0d required 4950", phase_s[0]);
    end
    // Reverse across zero: 4950 -> 150 is +200 the short way.
    phase[0] = 13'd150;
    run_sweep(lat);
    n_checks++;
    if (phase_s[0] !== 13'd50) begin
      n_fail++; $display("FAIL phase_wrap_up: got %0d required 50", phase_s[0]);
    end
    // Backward move without wrap: 50 -> 0 within one step.
    phase[0] = 13'd0;
    run_sweep(lat);
    n_checks++;
    if (phase_s[0] !== 13'd0) begin
      n_fail++; $display("FAIL phase_down: got %0d required 0", phase_s[0]);
    end
  endtask

  task automatic test_bypass();
    int lat;
    int bad;
    enable = 1'b0; step_duty = 13'd1; step_phase = 13'd1;
    for (int i = 0; i < D; i++) begin
      duty[i]  = W'($urandom_range(0, 5000));
      phase[i] = W'($urandom_range(0, 4999));
      exp_d[i] = duty[i];
      exp_p[i] = phase[i];
    end
    duty[0] = 13'd1000; exp_d[0] = 13'd1000;
    duty[5] = 13'd6000; exp_d[5] = 13'd5000;
    phase[5] = 13'd7000; exp_p[5] = 13'd2000;
    phase[6] = 13'd5000; exp_p[6] = 13'd0;
    run_sweep(lat);
    n_checks++;
    if (lat !== 251) begin
      n_fail++; $display("FAIL bypass_latency: got %0d required 251", lat);
    end
    bad = 0;
    for (int i = 0; i < D; i++) begin
      if (duty_s[i] !== exp_d[i] || phase_s[i] !== exp_p[i]) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bypass_values: %0d channels differ, required 0", bad);
    end
    n_checks++;
    if (duty_s[5] !== 13'd5000 || phase_s[5] !== 13'd2000) begin
      n_fail++; $display("FAIL sanitise: got %0d/%0d required 5000/2000", duty_s[5], phase_s[5]);
    end
  endtask

  task automatic test_overrun();
    int lat;
    int seen_ovr;
    enable = 1'b1; step_duty = 13'd100; step_phase = 13'd100;
    duty[0] = 13'd1500;
    lat = -1;
    seen_ovr = 0;
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 9) start = 1'b1;
      if (c == 10) begin
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
          n_fail++; $display("FAIL overrun_pulse: got ovr=%b busy=%b required 1/1", overrun, busy);
        end
      end
      if (c == 11) begin
        n_checks++;
        if (overrun !== 1'b0) begin
          n_fail++; $display("FAIL overrun_width: got %b required 0", overrun);
        end
      end
      if (overrun && c != 10) seen_ovr++;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lat !== 251 || seen_ovr != 0) begin
      n_fail++; $display("FAIL overrun_sweep: latency %0d extra %0d required 251 0", lat, seen_ovr);
    end
    n_checks++;
    if (duty_s[0] !== 13'd1100 || busy !== 1'b0) begin
      n_fail++; $display("FAIL overrun_result: got %0d busy %b required 1100 0", duty_s[0], busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    start = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (duty_s[0] !== 13'd0 || duty_s[200] !== 13'd0 || phase_s[5] !== 13'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %0d/%0d/%0d busy %b required 0/0/0/0",
               duty_s[0], duty_s[200], phase_s[5], busy);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_converge();
    int lat;
    int bad;
    enable = 1'b1; step_duty = 13'd100; step_phase = 13'd100;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < D; i++) begin
        duty[i]  = W'($urandom_range(0, 5000));
        phase[i] = W'($urandom_range(0, 4999));
      end
      repeat (55) run_sweep(lat);
      bad = 0;
      for (int i = 0; i < D; i++) begin
        if (duty_s[i] !== duty[i] || phase_s[i] !== phase[i]) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL converge_%0d: %0d channels differ, required 0", pass, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty_ramp();
    test_clamp();
    test_phase_wrap();
    test_bypass();
    test_overrun();
    test_reset_mid_sweep();
    test_converge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
